// File: rtl/nem_ohmux_sel_seq.sv
// Select sequencer for the NEM one-hot inverting mux.
// Converts binary select requests into one-hot relay drives with
// break-before-make dead time and a settle interval before SEL_VALID.
module nem_ohmux_sel_seq #(
    parameter int N_IN     = 4,
    parameter int SEL_W    = 2,
    parameter int T_BREAK  = 3,
    parameter int T_SETTLE = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [SEL_W-1:0] REQ_SEL,
    input  logic             REQ_OFF,
    output logic [N_IN-1:0]  S,
    output logic             SEL_VALID,
    output logic [SEL_W-1:0] CUR_SEL,
    output logic             REQ_ERR
);

    localparam int CNT_MAX = (T_BREAK > T_SETTLE) ? T_BREAK : T_SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SEL_W:0]   N_IN_L     = (SEL_W+1)'(N_IN);
    localparam logic [CNT_W-1:0] BREAK_LAST  = CNT_W'(T_BREAK - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(T_SETTLE - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_BREAK  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ON     = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_IN-1:0]  s_q;
    logic             sel_valid_q;
    logic [SEL_W-1:0] cur_sel_q;
    logic             req_err_q;
    logic             pend_off_q;
    logic [SEL_W-1:0] pend_sel_q;

    logic accept_d;
    logic req_bad_d;
    logic req_off_d;

    // Decode the incoming request: out-of-range selects are treated as "open all".
    always_comb begin
        accept_d  = REQ_VALID && REQ_READY;
        req_bad_d = !REQ_OFF && ({1'b0, REQ_SEL} >= N_IN_L);
        req_off_d = REQ_OFF || req_bad_d;
    end

    // Binary index to one-hot relay drive.
    function automatic logic [N_IN-1:0] onehot(input logic [SEL_W-1:0] k);
        logic [N_IN-1:0] r;
        r = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (SEL_W'(i) == k) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Requests are only taken while no relay transition is in flight.
    assign REQ_READY = (state_q == ST_OFF) || (state_q == ST_ON);

    // Sequencer FSM with registered relay drive and status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            s_q         <= '0;
            sel_valid_q <= 1'b0;
            cur_sel_q   <= '0;
            req_err_q   <= 1'b0;
            pend_off_q  <= 1'b0;
            pend_sel_q  <= '0;
        end else begin
            req_err_q <= accept_d && req_bad_d;
            case (state_q)
                ST_OFF: begin
                    if (accept_d && !req_off_d) begin
                        s_q       <= onehot(REQ_SEL);
                        cur_sel_q <= REQ_SEL;
                        cnt_q     <= '0;
                        state_q   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q       <= '0;
                        sel_valid_q <= 1'b1;
                        state_q     <= ST_ON;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ON: begin
                    // Re-selecting the closed path is a no-op; anything else breaks first.
                    if (accept_d && (req_off_d || (REQ_SEL != cur_sel_q))) begin
                        s_q         <= '0;
                        sel_valid_q <= 1'b0;
                        pend_off_q  <= req_off_d;
                        pend_sel_q  <= REQ_SEL;
                        cnt_q       <= '0;
                        state_q     <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (cnt_q == BREAK_LAST) begin
                        cnt_q <= '0;
                        if (pend_off_q) begin
                            state_q <= ST_OFF;
                        end else begin
                            s_q       <= onehot(pend_sel_q);
                            cur_sel_q <= pend_sel_q;
                            state_q   <= ST_SETTLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    s_q     <= '0;
                end
            endcase
        end
    end

    assign S         = s_q;
    assign SEL_VALID = sel_valid_q;
    assign CUR_SEL   = cur_sel_q;
    assign REQ_ERR   = req_err_q;

endmodule
